// File: rtl/pool2_feeder.sv
// Buffers NICE datapath words in a local FIFO and streams one ROWS x COL frame into the 2x2 pooling unit.
// Optional build macro POOL2_FEEDER_ROW_BURST_EN: each row is emitted as one gap-free burst of COL words.
module pool2_feeder #(
  parameter int DW         = 96,
  parameter int COL        = 16,
  parameter int ROWS       = 16,
  parameter int FIFO_DEPTH = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          wr_valid,
  input  logic [DW-1:0] wr_data,
  output logic          wr_ready,
  output logic          pool_en,
  output logic          pool_valid,
  output logic [DW-1:0] pool_data,
  input  logic          pool_end,
  output logic          busy,
  output logic          done,
  output logic          err
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = (COL > 1) ? $clog2(COL) : 1;
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;

  localparam logic [AW:0]   FULL_CNT = (AW+1)'(FIFO_DEPTH);
  localparam logic [CW-1:0] COL_LAST = CW'(COL - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(ROWS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t          state_reg;
  logic [DW-1:0]   mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr_reg;
  logic [AW-1:0]   rd_ptr_reg;
  logic [AW:0]     count_reg;
  logic [CW-1:0]   col_cnt_reg;
  logic [RW-1:0]   row_cnt_reg;
  logic            pool_en_reg;
  logic            pool_valid_reg;
  logic [DW-1:0]   pool_data_reg;
  logic            busy_reg;
  logic            done_reg;
  logic            err_reg;

  logic            push;
  logic            pop;
  logic            pop_ok;
  logic            last_pop;

  assign wr_ready = (count_reg < FULL_CNT);
  assign push     = wr_valid && wr_ready;

`ifdef POOL2_FEEDER_ROW_BURST_EN
  localparam logic [AW:0] ROW_CNT = (AW+1)'(COL);
  // A row only starts once all of it is buffered; the rest of the row then cannot underrun.
  assign pop_ok = (col_cnt_reg != '0) || (count_reg >= ROW_CNT);
`else
  assign pop_ok = (count_reg != '0);
`endif

  assign pop      = (state_reg == S_RUN) && pop_ok;
  assign last_pop = pop && (col_cnt_reg == COL_LAST) && (row_cnt_reg == ROW_LAST);

  // Storage array has no reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_reg] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      count_reg      <= '0;
      pool_valid_reg <= 1'b0;
      pool_data_reg  <= '0;
    end else begin
      pool_valid_reg <= pop;
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (pop) begin
        rd_ptr_reg    <= rd_ptr_reg + 1'b1;
        pool_data_reg <= mem[rd_ptr_reg];
      end
      case ({push, pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= S_IDLE;
      col_cnt_reg <= '0;
      row_cnt_reg <= '0;
      pool_en_reg <= 1'b0;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
      err_reg     <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          if (start) begin
            state_reg   <= S_RUN;
            col_cnt_reg <= '0;
            row_cnt_reg <= '0;
            err_reg     <= 1'b0;
            pool_en_reg <= 1'b1;
            busy_reg    <= 1'b1;
          end
        end
        S_RUN: begin
          // The pooling unit ended its frame before we finished feeding it.
          if (pool_end) begin
            err_reg <= 1'b1;
          end
          if (pop) begin
            if (col_cnt_reg == COL_LAST) begin
              col_cnt_reg <= '0;
              row_cnt_reg <= row_cnt_reg + 1'b1;
            end else begin
              col_cnt_reg <= col_cnt_reg + 1'b1;
            end
            if (last_pop) begin
              state_reg <= S_DRAIN;
            end
          end
        end
        S_DRAIN: begin
          if (pool_end) begin
            state_reg <= S_DONE;
            done_reg  <= 1'b1;
          end
        end
        default: begin
          state_reg   <= S_IDLE;
          pool_en_reg <= 1'b0;
          busy_reg    <= 1'b0;
        end
      endcase
    end
  end

  assign pool_en    = pool_en_reg;
  assign pool_valid = pool_valid_reg;
  assign pool_data  = pool_data_reg;
  assign busy       = busy_reg;
  assign done       = done_reg;
  assign err        = err_reg;

endmodule

// File: tb/tb_pool2_feeder.sv
// Randomized-data bench for pool2_feeder: queue-based frame model plus literal timing and sequence checks.
`timescale 1ns/1ps
module tb_pool2_feeder;

  localparam int DW    = 96;
  localparam int COL   = 16;
  localparam int ROWS  = 16;
  localparam int DEPTH = 32;
  localparam int FRAME = COL * ROWS;

  localparam int P_IDLE  = 0;
  localparam int P_RUN   = 1;
  localparam int P_DRAIN = 2;
  localparam int P_DONE  = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          wr_valid;
  logic [DW-1:0] wr_data;
  logic          wr_ready;
  logic          pool_en;
  logic          pool_valid;
  logic [DW-1:0] pool_data;
  logic          pool_end;
  logic          busy;
  logic          done;
  logic          err;

  pool2_feeder #(
    .DW(DW), .COL(COL), .ROWS(ROWS), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst(rst), .start(start),
    .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready),
    .pool_en(pool_en), .pool_valid(pool_valid), .pool_data(pool_data),
    .pool_end(pool_end), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  // Frame model: a queue of accepted words and a count of words sent this frame.
  logic [DW-1:0] q[$];
  int            ph     = P_IDLE;
  int            sent   = 0;
  logic          m_valid = 1'b0;
  logic [DW-1:0] m_data  = '0;
  logic          m_err   = 1'b0;

  always @(posedge clk) begin : model
    bit p;
    bit u;
    if (rst) begin
      q.delete();
      ph      = P_IDLE;
      sent    = 0;
      m_valid = 1'b0;
      m_data  = '0;
      m_err   = 1'b0;
    end else begin
      p = 1'b0;
      if (ph == P_RUN) begin
`ifdef POOL2_FEEDER_ROW_BURST_EN
        p = (q.size() > 0) && (((sent % COL) != 0) || (q.size() >= COL));
`else
        p = (q.size() > 0);
`endif
      end
      u = wr_valid && (q.size() < DEPTH);
      m_valid = p;
      if (p) m_data = q.pop_front();
      if (u) q.push_back(wr_data);
      case (ph)
        P_IDLE:  if (start) begin ph = P_RUN; sent = 0; m_err = 1'b0; end
        P_RUN: begin
          if (pool_end) m_err = 1'b1;
          if (p) begin
            sent++;
            if (sent == FRAME) ph = P_DRAIN;
          end
        end
        P_DRAIN: if (pool_end) ph = P_DONE;
        default: ph = P_IDLE;
      endcase
    end
  end

  int          total = 0;
  int          bad   = 0;
  int          vcnt  = 0;
  int          vbase = 0;
  int          dcnt  = 0;
  int          wr_timeout = 0;
  logic [31:0] widx    = '0;
  logic [31:0] seq_idx = '0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // One cycle: sample away from the edge, compare everything against the model.
  task automatic tick();
    @(negedge clk);
    #1;
    if (pool_valid) begin
      vcnt++;
      chk("seq", pool_data[31:0], seq_idx);
      seq_idx++;
    end
    if (done) dcnt++;
    chk("wr_ready", wr_ready, q.size() < DEPTH);
    chk("pool_en", pool_en, ph != P_IDLE);
    chk("busy", busy, ph != P_IDLE);
    chk("done", done, ph == P_DONE);
    chk("pool_valid", pool_valid, m_valid);
    chk("pool_data", pool_data, m_data);
    chk("err", err, m_err);
  endtask

  task automatic write_words(input int n, input int gap, input int budget);
    int i = 0;
    int k = 0;
    while (i < n && k < budget) begin
      @(negedge clk);
      k++;
      wr_valid = 1'b1;
      wr_data  = {$urandom(), $urandom(), widx};
      #1;
      if (wr_ready) begin
        i++;
        widx++;
        for (int g = 1; g < gap; g++) begin
          @(negedge clk);
          k++;
          wr_valid = 1'b0;
        end
      end
    end
    if (i < n) wr_timeout++;
    @(negedge clk);
    wr_valid = 1'b0;
  endtask

  task automatic wait_words(input int n, input int budget);
    int k = 0;
    while ((vcnt - vbase) < n && k < budget) begin
      tick();
      k++;
    end
    chk("word_count", vcnt - vbase, n);
  endtask

  task automatic pulse_start();
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic finish_frame(input int delay);
    repeat (delay) tick();
    pool_end = 1'b1;
    tick();
    pool_end = 1'b0;
    chk("done_after_end", done, 1'b1);
    tick();
    chk("busy_after_done", busy, 1'b0);
    chk("done_one_cycle", done, 1'b0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; wr_valid = 1'b0; wr_data = '0; pool_end = 1'b0;
    repeat (3) tick();
    chk("rst_wr_ready", wr_ready, 1'b1);
    chk("rst_pool_en", pool_en, 1'b0);
    chk("rst_pool_data", pool_data, '0);
    chk("rst_busy", busy, 1'b0);
    rst = 1'b0;
    tick();

    // Prefill to full, then a back-to-back frame.
    fork
      write_words(DEPTH, 1, 100);
      repeat (40) tick();
    join
    chk("prefill_full_ready", wr_ready, 1'b0);
    vbase = vcnt;
    pulse_start();
    chk("start_pool_en", pool_en, 1'b1);
    chk("start_no_valid_yet", pool_valid, 1'b0);
    tick();
    chk("first_valid_t2", pool_valid, 1'b1);
    chk("first_word", pool_data[31:0], 32'd0);
    fork
      write_words(FRAME - DEPTH, 1, 600);
      wait_words(FRAME, 600);
    join
    finish_frame(5);
    chk("frame1_words", vcnt - vbase, FRAME);

    // Trickle, with start ignored in RUN and DRAIN, pool_end ignored in IDLE.
    vbase = vcnt;
    pulse_start();
    fork
      write_words(FRAME, 3, 1500);
      begin
        wait_words(10, 200);
        pulse_start();
        wait_words(FRAME, 1500);
      end
    join
    pulse_start();
    chk("drain_ignores_start", busy, 1'b1);
    finish_frame(1);
    tick();
    pool_end = 1'b1;
    tick();
    pool_end = 1'b0;
    tick();
    chk("idle_ignores_end", busy, 1'b0);
    chk("done_count_2", dcnt, 2);

    // Continuous writes keeping the FIFO full while popping; 32 words stay queued.
    fork
      write_words(FRAME + DEPTH, 1, 800);
      begin
        repeat (10) tick();
        vbase = vcnt;
        pulse_start();
        wait_words(FRAME, 600);
      end
    join
    finish_frame(1);
    chk("leftover_full", wr_ready, 1'b0);

    // Early pool_end: err set, frame still completes, next start clears it.
    vbase = vcnt;
    pulse_start();
    fork
      write_words(FRAME - DEPTH, 1, 600);
      begin
        wait_words(100, 300);
        pool_end = 1'b1;
        tick();
        pool_end = 1'b0;
        chk("early_end_err", err, 1'b1);
        wait_words(FRAME, 600);
      end
    join
    finish_frame(3);
    chk("err_sticky", err, 1'b1);
    pulse_start();
    chk("start_clears_err", err, 1'b0);

    // Mid-frame reset.
    vbase = vcnt;
    fork
      write_words(64, 1, 300);
      begin
        wait_words(50, 300);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_pool_en", pool_en, 1'b0);
        chk("mid_rst_valid", pool_valid, 1'b0);
        chk("mid_rst_data", pool_data, '0);
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_wr_ready", wr_ready, 1'b1);
      end
    join
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    widx = '0;
    seq_idx = '0;
    tick();
    vbase = vcnt;
    pulse_start();
    fork
      write_words(FRAME, 1, 600);
      wait_words(FRAME, 600);
    join
    finish_frame(4);

    chk("done_count_total", dcnt, 5);
    chk("writer_completed", wr_timeout, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

endmodule
